// File: rtl/gen_estimulos_pkg.sv
// gen_estimulos_pkg
//   Shared definitions for the stimulus generator:
//   - state_t   : FSM state encoding (IDLE, INIT, PUSH, DRAIN, DONE)
//   - lfsr_taps : default Galois feedback masks (right-shift form) for
//                 maximal-length LFSRs of width 4..16
package gen_estimulos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_PUSH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Right-shift Galois form: if q[0] is set, q_next = (q >> 1) ^ taps.
    // Every mask has its MSB set, so the update is invertible and a
    // nonzero state never collapses to zero.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_0009;
            5:       taps = 32'h0000_0012;
            6:       taps = 32'h0000_0021;
            7:       taps = 32'h0000_0041;
            8:       taps = 32'h0000_008E;
            9:       taps = 32'h0000_0108;
            10:      taps = 32'h0000_0204;
            11:      taps = 32'h0000_0402;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_4001;
            16:      taps = 32'h0000_8016;
            // Unsupported width: plain rotate keeps the state nonzero but is
            // not maximal-length.
            default: taps = 32'h0000_0001 << (width - 1);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/gen_estimulos_lfsr_gen.sv
// lfsr_gen
//   Galois LFSR, right-shift form.
//   Ports:
//     clk    in          rising-edge clock
//     reset  in          asynchronous, active-high; q <= RESET_VALUE
//     load   in          q <= seed (has priority over enable)
//     seed   in  WIDTH   value loaded by load
//     enable in          advance one step
//     q      out WIDTH   current LFSR state
module lfsr_gen
    import gen_estimulos_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(lfsr_taps(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= seed;
        end else if (enable) begin
            q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/gen_estimulos.sv
// gen_estimulos
//   Stimulus generator for a multi-channel buffer DUT. A run is:
//   INIT (one-cycle init pulse, thresholds presented) -> PUSH (NUM_WORDS
//   LFSR words, throttled by Main_pause) -> DRAIN (pop mirrors can_pop until
//   DRAIN_IDLE idle cycles) -> DONE.
//   Ports:
//     clk, reset                 clock, async active-high reset
//     start                      one-cycle run request (IDLE/DONE only)
//     mode_rr                    1: channel field carries round-robin index
//     cfg_umbral_MF/VC/D [LENGTH] thresholds, sampled at start
//     Main_pause                 backpressure from the DUT
//     can_pop [NUM_CH]           per-channel data-available flags
//     init                       one-cycle initialisation pulse
//     Umbral_MF/VC/D [LENGTH]    registered thresholds
//     push, data_in [BITNUMBER]  stimulus word and its valid
//     pop [NUM_CH]               per-channel pop
//     done                       run complete
//     words_sent                 pushes issued in the current run
//     fsm_state                  current FSM state (observation only)
//
//   Push handshake: the value of Main_pause seen at a rising edge decides
//   that edge. Main_pause=0 -> push=1 with a fresh word for the following
//   cycle; Main_pause=1 -> push=0 and data_in keeps its previous word. A
//   word counts as sent in the cycle push is high.
module gen_estimulos
    import gen_estimulos_pkg::*;
#(
    parameter int          BITNUMBER  = 8,
    parameter int          LENGTH     = 8,
    parameter int          NUM_CH     = 2,
    parameter int          NUM_WORDS  = 16,
    parameter int unsigned SEED       = 8'h5A,
    parameter int          CH_LSB     = 4,
    parameter int          DRAIN_IDLE = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             mode_rr,
    input  logic [LENGTH-1:0]                cfg_umbral_MF,
    input  logic [LENGTH-1:0]                cfg_umbral_VC,
    input  logic [LENGTH-1:0]                cfg_umbral_D,
    input  logic                             Main_pause,
    input  logic [NUM_CH-1:0]                can_pop,
    output logic                             init,
    output logic [LENGTH-1:0]                Umbral_MF,
    output logic [LENGTH-1:0]                Umbral_VC,
    output logic [LENGTH-1:0]                Umbral_D,
    output logic                             push,
    output logic [BITNUMBER-1:0]             data_in,
    output logic [NUM_CH-1:0]                pop,
    output logic                             done,
    output logic [$clog2(NUM_WORDS+1)-1:0]   words_sent,
    output state_t                           fsm_state
);

    localparam int CW  = $clog2(NUM_CH);
    localparam int WSW = $clog2(NUM_WORDS + 1);
    localparam int IDW = $clog2(DRAIN_IDLE + 1);

    // A seed that truncates to zero would lock the LFSR; fall back to 1.
    localparam logic [BITNUMBER-1:0] SEED_T   = BITNUMBER'(SEED);
    localparam logic [BITNUMBER-1:0] SEED_EFF = (SEED_T == '0) ? BITNUMBER'(1) : SEED_T;

    state_t state, state_n;

    logic [LENGTH-1:0]    cfg_mf_q, cfg_vc_q, cfg_d_q;
    logic [LENGTH-1:0]    cfg_mf_n, cfg_vc_n, cfg_d_n;
    logic [LENGTH-1:0]    mf_n, vc_n, d_n;
    logic                 mode_q, mode_n;
    logic [CW-1:0]        ch_q, ch_n, ch_inc;
    logic [IDW-1:0]       idle_q, idle_n;
    logic                 init_n, push_n, done_n;
    logic [BITNUMBER-1:0] data_n, word, lfsr_q;
    logic [NUM_CH-1:0]    pop_n;
    logic [WSW-1:0]       ws_n;
    logic                 lfsr_load, lfsr_en;

    lfsr_gen #(
        .WIDTH       (BITNUMBER),
        .TAPS        (BITNUMBER'(lfsr_taps(BITNUMBER))),
        .RESET_VALUE (SEED_EFF)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (lfsr_load),
        .seed   (SEED_EFF),
        .enable (lfsr_en),
        .q      (lfsr_q)
    );

    assign fsm_state = state;
    assign ch_inc    = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        init_n    = 1'b0;
        push_n    = 1'b0;
        pop_n     = '0;
        data_n    = data_in;
        done_n    = done;
        ws_n      = words_sent;
        mf_n      = Umbral_MF;
        vc_n      = Umbral_VC;
        d_n       = Umbral_D;
        cfg_mf_n  = cfg_mf_q;
        cfg_vc_n  = cfg_vc_q;
        cfg_d_n   = cfg_d_q;
        mode_n    = mode_q;
        ch_n      = ch_q;
        idle_n    = idle_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        // Candidate word: current LFSR state, optionally with the channel
        // field overwritten by the round-robin index.
        word = lfsr_q;
        if (mode_q) begin
            word[CH_LSB +: CW] = ch_q;
        end

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n   = ST_INIT;
                    init_n    = 1'b1;
                    // Thresholds go out straight from the inputs so that
                    // they are valid during the init pulse itself.
                    cfg_mf_n  = cfg_umbral_MF;
                    cfg_vc_n  = cfg_umbral_VC;
                    cfg_d_n   = cfg_umbral_D;
                    mf_n      = cfg_umbral_MF;
                    vc_n      = cfg_umbral_VC;
                    d_n       = cfg_umbral_D;
                    mode_n    = mode_rr;
                    ws_n      = '0;
                    done_n    = 1'b0;
                    ch_n      = '0;
                    idle_n    = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_INIT: begin
                state_n = ST_PUSH;
                mf_n    = cfg_mf_q;
                vc_n    = cfg_vc_q;
                d_n     = cfg_d_q;
            end
            ST_PUSH: begin
                if (words_sent == WSW'(NUM_WORDS)) begin
                    state_n = ST_DRAIN;
                end else if (!Main_pause) begin
                    push_n  = 1'b1;
                    data_n  = word;
                    lfsr_en = 1'b1;
                    ws_n    = words_sent + WSW'(1);
                    ch_n    = ch_inc;
                end
            end
            ST_DRAIN: begin
                if (can_pop != '0) begin
                    pop_n  = can_pop;
                    idle_n = '0;
                end else if (idle_q == IDW'(DRAIN_IDLE - 1)) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    idle_n = idle_q + IDW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init       <= 1'b0;
            push       <= 1'b0;
            data_in    <= '0;
            pop        <= '0;
            done       <= 1'b0;
            words_sent <= '0;
            Umbral_MF  <= '0;
            Umbral_VC  <= '0;
            Umbral_D   <= '0;
            cfg_mf_q   <= '0;
            cfg_vc_q   <= '0;
            cfg_d_q    <= '0;
            mode_q     <= 1'b0;
            ch_q       <= '0;
            idle_q     <= '0;
        end else begin
            init       <= init_n;
            push       <= push_n;
            data_in    <= data_n;
            pop        <= pop_n;
            done       <= done_n;
            words_sent <= ws_n;
            Umbral_MF  <= mf_n;
            Umbral_VC  <= vc_n;
            Umbral_D   <= d_n;
            cfg_mf_q   <= cfg_mf_n;
            cfg_vc_q   <= cfg_vc_n;
            cfg_d_q    <= cfg_d_n;
            mode_q     <= mode_n;
            ch_q       <= ch_n;
            idle_q     <= idle_n;
        end
    end

endmodule

// File: tb/tb_gen_estimulos.sv
// tb_gen_estimulos
//   Directed bench for gen_estimulos with default parameters. Inputs change
//   1 time unit after a rising edge; outputs are sampled at that same point.
module tb_gen_estimulos;
    import gen_estimulos_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode_rr;
    logic [7:0] cfg_umbral_MF, cfg_umbral_VC, cfg_umbral_D;
    logic       Main_pause;
    logic [1:0] can_pop;
    logic       init;
    logic [7:0] Umbral_MF, Umbral_VC, Umbral_D;
    logic       push;
    logic [7:0] data_in;
    logic [1:0] pop;
    logic       done;
    logic [4:0] words_sent;
    state_t     fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-stepped from seed 8'h5A with Galois right-shift taps 8'h8E.
    logic [7:0] tbl [16] = '{8'h5A, 8'h2D, 8'h98, 8'h4C, 8'h26, 8'h13, 8'h87, 8'hCD,
                             8'hE8, 8'h74, 8'h3A, 8'h1D, 8'h80, 8'h40, 8'h20, 8'h10};

    gen_estimulos dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mode_rr       (mode_rr),
        .cfg_umbral_MF (cfg_umbral_MF),
        .cfg_umbral_VC (cfg_umbral_VC),
        .cfg_umbral_D  (cfg_umbral_D),
        .Main_pause    (Main_pause),
        .can_pop       (can_pop),
        .init          (init),
        .Umbral_MF     (Umbral_MF),
        .Umbral_VC     (Umbral_VC),
        .Umbral_D      (Umbral_D),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .done          (done),
        .words_sent    (words_sent),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] mf, input logic [7:0] vc, input logic [7:0] d,
                               input logic rr, input logic pause);
        cfg_umbral_MF = mf;
        cfg_umbral_VC = vc;
        cfg_umbral_D  = d;
        mode_rr       = rr;
        Main_pause    = pause;
        start         = 1'b1;
        tick();
        start         = 1'b0;
        Main_pause    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode_rr = 1'b0; Main_pause = 1'b0; can_pop = 2'b00;
        cfg_umbral_MF = 8'd0; cfg_umbral_VC = 8'd0; cfg_umbral_D = 8'd0;
        #2;
        n_checks++;
        if ({init, push, data_in, pop, done, words_sent, Umbral_MF, Umbral_VC, Umbral_D} !== '0)
            $display("FAIL reset_outputs: got %b want all zero",
                     {init, push, data_in, pop, done, words_sent, Umbral_MF, Umbral_VC, Umbral_D});
        else n_pass++;
        n_checks++;
        if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE);
        else n_pass++;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (fsm_state !== ST_IDLE || push !== 1'b0 || init !== 1'b0)
            $display("FAIL idle_after_reset: state=%0d push=%b init=%b want IDLE,0,0", fsm_state, push, init);
        else n_pass++;
    endtask

    task automatic test_basic_run();
        pulse_start(8'd10, 8'd20, 8'd30, 1'b0, 1'b0);
        n_checks++;
        if (init !== 1'b1 || fsm_state !== ST_INIT)
            $display("FAIL basic_init: init=%b state=%0d want 1,INIT", init, fsm_state);
        else n_pass++;
        n_checks++;
        if ({Umbral_MF, Umbral_VC, Umbral_D} !== {8'd10, 8'd20, 8'd30})
            $display("FAIL basic_umbral: got %0d,%0d,%0d want 10,20,30", Umbral_MF, Umbral_VC, Umbral_D);
        else n_pass++;
        tick();
        n_checks++;
        if (init !== 1'b0 || push !== 1'b0 || fsm_state !== ST_PUSH)
            $display("FAIL basic_init_len: init=%b push=%b state=%0d want 0,0,PUSH", init, push, fsm_state);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (push !== 1'b1 || data_in !== tbl[i] || words_sent !== 5'(i + 1))
                $display("FAIL basic_push[%0d]: push=%b data=%h ws=%0d want 1,%h,%0d",
                         i, push, data_in, words_sent, tbl[i], i + 1);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (push !== 1'b0 || fsm_state !== ST_DRAIN || words_sent !== 5'd16)
            $display("FAIL basic_to_drain: push=%b state=%0d ws=%0d want 0,DRAIN,16", push, fsm_state, words_sent);
        else n_pass++;
        can_pop = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (pop !== 2'b01 || done !== 1'b0)
                $display("FAIL drain_pop[%0d]: pop=%b done=%b want 01,0", k, pop, done);
            else n_pass++;
        end
        can_pop = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (pop !== 2'b00 || done !== 1'b0)
                $display("FAIL drain_idle[%0d]: pop=%b done=%b want 00,0", k, pop, done);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || pop !== 2'b00 || push !== 1'b0 || fsm_state !== ST_DONE)
            $display("FAIL drain_done: done=%b pop=%b push=%b state=%0d want 1,00,0,DONE",
                     done, pop, push, fsm_state);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if (done !== 1'b1 || {Umbral_MF, Umbral_VC, Umbral_D} !== {8'd10, 8'd20, 8'd30} || init !== 1'b0)
            $display("FAIL done_hold: done=%b umbral=%0d,%0d,%0d init=%b want 1,10,20,30,0",
                     done, Umbral_MF, Umbral_VC, Umbral_D, init);
        else n_pass++;
    endtask

    task automatic test_restart_rr();
        logic [7:0] exp;
        pulse_start(8'd4, 8'd6, 8'd0, 1'b1, 1'b0);
        mode_rr = 1'b0;  // must already be latched
        n_checks++;
        if (done !== 1'b0 || init !== 1'b1)
            $display("FAIL restart_done_clr: done=%b init=%b want 0,1", done, init);
        else n_pass++;
        n_checks++;
        if ({Umbral_MF, Umbral_VC, Umbral_D} !== {8'd4, 8'd6, 8'd0})
            $display("FAIL restart_umbral: got %0d,%0d,%0d want 4,6,0", Umbral_MF, Umbral_VC, Umbral_D);
        else n_pass++;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 6) start = 1'b1;  // ignored while in PUSH
            tick();
            start = 1'b0;
            exp = tbl[i];
            exp[4] = i[0];
            n_checks++;
            if (push !== 1'b1 || data_in !== exp || words_sent !== 5'(i + 1) || init !== 1'b0)
                $display("FAIL rr_push[%0d]: push=%b data=%h ws=%0d init=%b want 1,%h,%0d,0",
                         i, push, data_in, words_sent, init, exp, i + 1);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (fsm_state !== ST_DRAIN || push !== 1'b0)
            $display("FAIL rr_to_drain: state=%0d push=%b want DRAIN,0", fsm_state, push);
        else n_pass++;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (done !== 1'b1 || fsm_state !== ST_DONE)
            $display("FAIL rr_done: done=%b state=%0d want 1,DONE", done, fsm_state);
        else n_pass++;
    endtask

    task automatic test_pause();
        int pushes = 0;
        pulse_start(8'd1, 8'd2, 8'd3, 1'b0, 1'b1);
        n_checks++;
        if (init !== 1'b1 || fsm_state !== ST_INIT)
            $display("FAIL pause_start_init: init=%b state=%0d want 1,INIT", init, fsm_state);
        else n_pass++;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (push === 1'b1) pushes++;
            n_checks++;
            if (push !== 1'b1 || data_in !== tbl[i])
                $display("FAIL pause_pre[%0d]: push=%b data=%h want 1,%h", i, push, data_in, tbl[i]);
            else n_pass++;
        end
        Main_pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (push === 1'b1) pushes++;
            n_checks++;
            if (push !== 1'b0 || data_in !== tbl[4] || words_sent !== 5'd5)
                $display("FAIL pause_hold[%0d]: push=%b data=%h ws=%0d want 0,%h,5",
                         k, push, data_in, words_sent, tbl[4]);
            else n_pass++;
        end
        Main_pause = 1'b0;
        for (int i = 5; i < 16; i++) begin
            tick();
            if (push === 1'b1) pushes++;
            n_checks++;
            if (push !== 1'b1 || data_in !== tbl[i])
                $display("FAIL pause_post[%0d]: push=%b data=%h want 1,%h", i, push, data_in, tbl[i]);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (push === 1'b1) pushes++;
        end
        n_checks++;
        if (pushes !== 16 || words_sent !== 5'd16 || fsm_state !== ST_DRAIN)
            $display("FAIL pause_total: pushes=%0d ws=%0d state=%0d want 16,16,DRAIN",
                     pushes, words_sent, fsm_state);
        else n_pass++;
        for (int k = 0; k < 2; k++) tick();
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL pause_done: done=%b want 1", done);
        else n_pass++;
    endtask

    task automatic test_reset_mid_push();
        pulse_start(8'd7, 8'd8, 8'd9, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (words_sent !== 5'd7 || data_in !== tbl[6])
            $display("FAIL midrun_pre: ws=%0d data=%h want 7,%h", words_sent, data_in, tbl[6]);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({init, push, data_in, pop, done, words_sent, Umbral_MF, Umbral_VC, Umbral_D} !== '0
            || fsm_state !== ST_IDLE)
            $display("FAIL midrun_reset: outs=%b state=%0d want zero,IDLE",
                     {init, push, data_in, pop, done, words_sent, Umbral_MF, Umbral_VC, Umbral_D}, fsm_state);
        else n_pass++;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (fsm_state !== ST_IDLE || push !== 1'b0 || pop !== 2'b00)
            $display("FAIL midrun_wait: state=%0d push=%b pop=%b want IDLE,0,00", fsm_state, push, pop);
        else n_pass++;
        pulse_start(8'd7, 8'd8, 8'd9, 1'b0, 1'b0);
        n_checks++;
        if (init !== 1'b1 || words_sent !== 5'd0 || {Umbral_MF, Umbral_VC, Umbral_D} !== {8'd7, 8'd8, 8'd9})
            $display("FAIL midrun_restart: init=%b ws=%0d umbral=%0d,%0d,%0d want 1,0,7,8,9",
                     init, words_sent, Umbral_MF, Umbral_VC, Umbral_D);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (push !== 1'b1 || data_in !== 8'h5A || words_sent !== 5'd1)
            $display("FAIL midrun_seed: push=%b data=%h ws=%0d want 1,5a,1", push, data_in, words_sent);
        else n_pass++;
        tick();
        n_checks++;
        if (data_in !== 8'h2D || words_sent !== 5'd2)
            $display("FAIL midrun_second: data=%h ws=%0d want 2d,2", data_in, words_sent);
        else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_run();
        test_restart_rr();
        test_pause();
        test_reset_mid_push();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gen_estimulos.md
GEN_ESTIMULOS -- requirements
Module: gen_estimulos

Interface
REQ-001 Parameter BITNUMBER, default 8: width of data_in.
REQ-002 Parameter LENGTH, default 8: width of each threshold output.
REQ-003 Parameter NUM_CH, default 2, range 2..8: number of output channels driven by pop.
REQ-004 Parameter NUM_WORDS, default 16: words pushed per run.
REQ-005 Parameter SEED, default 8'h5A: nonzero LFSR seed, truncated or zero-extended to BITNUMBER.
REQ-006 Parameter CH_LSB, default 4: LSB of the channel-select field inside data_in.
REQ-007 Parameter DRAIN_IDLE, default 4: consecutive idle cycles that end DRAIN.
REQ-008 Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- mode_rr  in  1  1 = channel field is round-robin; 0 = raw LFSR data; sampled at start.
- cfg_umbral_MF, cfg_umbral_VC, cfg_umbral_D  in  LENGTH  thresholds, sampled at start.
- Main_pause  in  1  backpressure from the DUT.
- can_pop  in  NUM_CH  per-channel data-available flags.
- init  out  1  one-cycle initialisation pulse.
- Umbral_MF, Umbral_VC, Umbral_D  out  LENGTH  registered thresholds.
- push  out  1  data_in valid.
- data_in  out  BITNUMBER  stimulus word.
- pop  out  NUM_CH  per-channel pop.
- done  out  1  run complete.
- words_sent  out  $clog2(NUM_WORDS+1)  pushes issued in the current run.

Function
REQ-009 FSM states are IDLE, INIT, PUSH, DRAIN, DONE; all outputs are registered.
REQ-010 On start in IDLE or DONE: latch the cfg_* inputs and mode_rr, clear words_sent, clear done, reload the LFSR with SEED, go to INIT.
REQ-011 INIT lasts exactly one cycle: init=1 and Umbral_* = latched cfg values, then go to PUSH; init is 0 in every other state.
REQ-012 PUSH, Main_pause=0 at a clock edge: push<=1, data_in<=next word, LFSR advances, words_sent increments.
REQ-013 PUSH, Main_pause=1 at a clock edge: push<=0, data_in holds, LFSR and words_sent hold.
REQ-014 LFSR is a Galois maximal-length LFSR over BITNUMBER bits; it never reaches zero.
REQ-015 mode_rr=1: data_in[CH_LSB +: $clog2(NUM_CH)] is replaced by the channel index, which starts at 0 and advances modulo NUM_CH per accepted word; all other bits come from the LFSR.
REQ-016 When words_sent reaches NUM_WORDS at a clock edge, go to DRAIN; push<=0 on that edge; no push occurs after NUM_WORDS.
REQ-017 DRAIN: pop[i]<=can_pop[i] each cycle. An idle counter resets whenever can_pop is nonzero. After DRAIN_IDLE consecutive cycles with can_pop all zero, go to DONE with pop<=0.
REQ-018 DONE: done=1; push, pop and init are 0; Umbral_* hold their values.
REQ-019 start received in INIT, PUSH or DRAIN is ignored.
REQ-020 start and Main_pause asserted in the same cycle: the run still enters INIT; Main_pause only affects PUSH.

Reset
REQ-021 While reset=1, asynchronously: state=IDLE, the LFSR holds SEED, and the following are 0: init, push, data_in, pop, done, words_sent, Umbral_*, latched cfg, channel index, idle counter.
REQ-022 Reset asserted mid-run aborts the run with no further push or pop; after release the block waits in IDLE for start.

Structure
REQ-023 A shared package holds the FSM state enumeration and the default LFSR tap masks for widths 4..16.
REQ-024 A single sub-module, lfsr_gen (ports: clk, reset, load, seed, enable, q), implements the LFSR.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Defaults, start pulse, Main_pause=0: init high for 1 cycle at the cycle after start; 16 consecutive push cycles; words_sent=16; then DRAIN.
- Main_pause high for 3 cycles mid-PUSH: push=0 and data_in stable for exactly those 3 cycles; total pushes remain 16.
- mode_rr=1, NUM_CH=2: data_in[4] alternates 0,1,0,1 across accepted words.
- In DRAIN, can_pop=2'b01 for 5 cycles then 0: pop=2'b01 for those 5 cycles; done=1 exactly 4 idle cycles later.
- Reset pulsed during PUSH after 7 words: all outputs are 0 immediately; a new start restarts from SEED with words_sent=0.
- start pulsed during PUSH: no effect; start pulsed in DONE: new run with newly latched cfg thresholds (e.g. 4,6,0).
